// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and constants for the memory arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int c_cnt_w = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_timeout : BUSY-cycle counter, flags the cycle whose edge     |
// | would bring the count to TIMEOUT.                                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [c_cnt_w-1:0] c_lim = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Counter reaches TIMEOUT on the edge that ends this cycle.
  assign o_expired = i_en && (r_cnt == c_lim);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : fetch/data to single memory port arbiter with timeout. |
// | Optional round-robin on simultaneous requests: MEM_ARB_RR_EN.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata,
  input  logic          m_ack,
  output logic          err,
  output logic [AW-1:0] err_addr
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_done;
  logic          w_abort;
  logic          w_busy;
  logic          w_expired;
  logic          w_pick_d;

  logic          r_m_req;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [31:0]   r_m_wdata;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_i_ready;
  logic          r_d_ready;
  logic          r_err;
  logic [AW-1:0] r_err_addr;

`ifdef MEM_ARB_RR_EN
  owner_e r_rr_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last <= OWN_I;
    end else if (w_grant_i) begin
      r_rr_last <= OWN_I;
    end else if (w_grant_d) begin
      r_rr_last <= OWN_D;
    end
  end

  // Data wins a tie only if fetch was the most recent grant.
  assign w_pick_d = d_req && (!i_req || (r_rr_last == OWN_I));
`else
  assign w_pick_d = d_req;
`endif

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

  mem_arb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_grant_i || w_grant_d),
    .i_en      (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_grant_d   = 1'b1;
          w_state_nxt = BUSY_D;
        end else if (i_req) begin
          w_grant_i   = 1'b1;
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack on the expiry cycle still counts as a normal completion.
        if (m_ack) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_i_ready  <= 1'b0;
      r_d_ready  <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_err     <= 1'b0;
      if (w_grant_d) begin
        r_m_req   <= 1'b1;
        r_m_we    <= d_we;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b0;
        r_m_addr  <= i_addr;
        r_m_wdata <= '0;
      end
      if (w_done || w_abort) begin
        r_m_req <= 1'b0;
        if (r_state == BUSY_I) begin
          r_i_ready <= 1'b1;
          r_i_rdata <= w_done ? m_rdata : 32'h0;
        end else begin
          r_d_ready <= 1'b1;
          r_d_rdata <= w_done ? m_rdata : 32'h0;
        end
      end
      if (w_abort) begin
        r_err      <= 1'b1;
        r_err_addr <= r_m_addr;
      end
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign i_ready  = r_i_ready;
  assign d_ready  = r_d_ready;
  assign err      = r_err;
  assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Directed self-checking bench for mem_arbiter (TIMEOUT=8).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, err_addr;
  logic        i_ready, d_ready, m_req, m_we, m_ack, err;

  logic        ack_r = 1'b0;
  logic        stray_ack = 1'b0;
  int          lat = 0;
  int          rcnt = 0;

  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err), .err_addr(err_addr)
  );

  assign m_ack = ack_r | stray_ack;

  // Memory model: ack one cycle, lat cycles after m_req rises (lat=0: never).
  always @(negedge clk) begin
    if (m_req) begin
      rcnt  = rcnt + 1;
      ack_r = (lat != 0) && (rcnt == lat + 1);
    end else begin
      rcnt  = 0;
      ack_r = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit want_d, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (want_d ? d_ready : i_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    int          icnt, dcnt, coll, hi, errs, nst, rdy;
    int          idone, ddone, dissued, gi, gd, badg, gapbad, lowrun, errc;
    bit          prev, started, stop;
    logic [31:0] exp2;

    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    tick(); tick();
    check("rst_flags", {m_req, m_we, i_ready, d_ready, err}, 0);
    check("rst_addr", {m_addr, err_addr}, 0);
    reset = 1'b0;
    tick();

    // Single fetch, L=1
    i_req = 1; i_addr = 32'h40; lat = 1; m_rdata = 32'h13;
    tick();
    check("t1_mreq_c1", m_req, 1);
    check("t1_maddr", {m_we, m_addr}, {1'b0, 32'h40});
    tick();
    check("t1_rdy_c2", i_ready, 0);
    tick();
    check("t1_rdy_c3", {i_ready, d_ready, m_req}, 3'b100);
    check("t1_rdata", i_rdata, 32'h13);
    i_req = 0;
    tick();
    check("t1_rdy_pulse", i_ready, 0);

    // Simultaneous requests: data first, then tie-break on re-request
    i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h100; d_we = 0;
    m_rdata = 32'hA5A5_0001;
    tick();
    check("t2_first_addr", m_addr, 32'h100);
    wait_rdy(1'b1, 10, ok);
    check("t2_d_rdy", ok, 1);
    check("t2_no_i_with_d", i_ready, 0);
    check("t2_d_rdata", d_rdata, 32'hA5A5_0001);
    d_addr = 32'h104; m_rdata = 32'h0BAD_F00D;
`ifdef MEM_ARB_RR_EN
    exp2 = 32'h80;
`else
    exp2 = 32'h104;
`endif
    tick();
    check("t2_second_grant", m_addr, exp2);
    icnt = 0; dcnt = 0; coll = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (i_ready && d_ready) coll++;
      if (i_ready) begin icnt++; i_req = 0; end
      if (d_ready) begin dcnt++; d_req = 0; end
    end
    check("t2_counts", {icnt[7:0], dcnt[7:0], coll[7:0]}, {8'd1, 8'd1, 8'd0});
    check("t2_i_rdata", i_rdata, 32'h0BAD_F00D);

    // Store, L=4
    d_req = 1; d_we = 1; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h200; lat = 4;
    nst = 0; dcnt = 0; icnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m_req && m_we && m_wdata == 32'hDEAD_BEEF && m_addr == 32'h200) nst++;
      if (i_ready) icnt++;
      if (d_ready) begin dcnt++; d_req = 0; d_we = 0; end
    end
    check("t3_stable_cycles", nst, 5);
    check("t3_d_pulses", dcnt, 1);
    check("t3_no_i_ready", icnt, 0);

    // Timeout abort on a fetch
    i_req = 1; i_addr = 32'h300; lat = 0;
    tick();
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (!m_req) break;
      hi++;
      tick();
    end
    check("t4_busy_cycles", hi, 8);
    check("t4_abort_flags", {i_ready, d_ready, err}, 3'b101);
    check("t4_abort_rdata", i_rdata, 0);
    check("t4_err_addr", err_addr, 32'h300);
    i_req = 0;
    tick();
    check("t4_err_pulse", err, 0);
    check("t4_err_addr_held", err_addr, 32'h300);

    // Ack on the expiry cycle completes normally
    d_req = 1; d_addr = 32'h400; d_we = 0; lat = 7; m_rdata = 32'h77;
    tick();
    hi = 0; errs = 0;
    for (int k = 0; k < 20; k++) begin
      if (d_ready) break;
      errs += int'(err);
      hi += int'(m_req);
      tick();
    end
    check("t4b_ready", d_ready, 1);
    check("t4b_busy_cycles", hi, 8);
    check("t4b_rdata", d_rdata, 32'h77);
    check("t4b_no_err", errs + int'(err), 0);
    check("t4b_err_addr", err_addr, 32'h300);
    d_req = 0;
    tick();

    // Async reset mid BUSY_D, then stray ack
    d_req = 1; d_addr = 32'h500; lat = 0;
    tick(); tick(); tick();
    check("t5_busy_before", m_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_flags", {m_req, m_we, i_ready, d_ready, err}, 0);
    check("t5_rst_addr", {m_addr, err_addr}, 0);
    check("t5_rst_rdata", {i_rdata, d_rdata}, 0);
    d_req = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    rdy = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      rdy += int'(i_ready) + int'(d_ready) + int'(m_req) + int'(err);
    end
    check("t5_stray_ack", rdy, 0);

    // Continuous fetch with periodic data requests
    lat = 2; i_req = 1; i_addr = 32'h1000;
    idone = 0; ddone = 0; dissued = 0; gi = 0; gd = 0; badg = 0;
    gapbad = 0; lowrun = 0; errc = 0; coll = 0;
    prev = 0; started = 0; stop = 0;
    for (int cyc = 0; cyc < 260; cyc++) begin
      tick();
      stop = (cyc >= 200);
      if (i_ready && d_ready) coll++;
      if (err) errc++;
      if (m_req) begin
        if (!prev) begin
          if (started && lowrun != 1) gapbad++;
          started = 1;
          if (d_req && m_addr == d_addr) gd++;
          else if (i_req && m_addr == i_addr) gi++;
          else badg++;
        end
        lowrun = 0;
      end else begin
        lowrun++;
      end
      prev = m_req;
      if (i_ready) begin
        idone++;
        if (stop) i_req = 0;
        else i_addr = i_addr + 4;
      end
      if (d_ready) begin
        ddone++;
        d_req = 0;
      end else if (!stop && (cyc % 5 == 0) && !d_req) begin
        d_req = 1;
        d_addr = 32'h8000 + 32'(dissued * 4);
        dissued++;
      end
      if (stop && !i_req && !d_req && !m_req) break;
    end
    check("t6_collisions", coll, 0);
    check("t6_gap", gapbad, 0);
    check("t6_bad_grant", badg, 0);
    check("t6_no_err", errc, 0);
    check("t6_i_once", gi, idone);
    check("t6_d_once", {gd[15:0], ddone[15:0]}, {dissued[15:0], dissued[15:0]});
    check("t6_progress", (idone > 20) && (dissued > 10), 1);
    check("t6_idle_end", {m_req, i_req, d_req}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
